// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } seg_scan_state_e;

  localparam int SEG_SCAN_PWM_W = 4;

endpackage

// File: rtl/seg_scan_next_sel.sv
// Wrap-around downward search for the next enabled digit, inclusive or
// exclusive of the start index, with a found flag when any digit is enabled.
module seg_scan_next_sel #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic [NUM_DIGITS-1:0] mask,
  input  logic [IDX_W-1:0]      start,
  input  logic                  inclusive,
  output logic [IDX_W-1:0]      sel,
  output logic                  found
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel      = start;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Walk from the farthest candidate to the nearest so the nearest match wins.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      cand     = (int'(start) + 2 * NUM_DIGITS - k - (inclusive ? 0 : 1)) % NUM_DIGITS;
      cand_idx = IDX_W'(cand);
      if (mask[cand_idx]) begin
        sel   = cand_idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment digit scanner with blanking gaps and runtime digit mask.
// Optional PWM dimming is enabled by defining SEG_SCAN_BRIGHTNESS_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [SEG_SCAN_PWM_W-1:0]     brightness,
`endif
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_index,
  output logic                          digit_valid,
  output logic                          tick
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_INIT   = IDX_W'(NUM_DIGITS - 1);
  // With no blanking gap a finished digit hands straight over to the next DRIVE.
  localparam seg_scan_state_e  GAP_STATE  = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

  seg_scan_state_e     state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [IDX_W-1:0]    index_d;
  logic [IDX_W-1:0]    next_idx;
  logic                next_found;
  logic                tick_d;
  logic                lit_d;
  logic [NUM_DIGITS-1:0] an_n_d;

  // IDLE searches from the held index inclusively; DRIVE advances strictly below.
  seg_scan_next_sel #(
    .NUM_DIGITS (NUM_DIGITS),
    .IDX_W      (IDX_W)
  ) u_next_sel (
    .mask      (digit_mask),
    .start     (digit_index),
    .inclusive (state == IDLE),
    .sel       (next_idx),
    .found     (next_found)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    index_d = digit_index;
    tick_d  = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_d = '0;
          if (next_found) begin
            index_d = next_idx;
            state_d = GAP_STATE;
          end
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt_d   = '0;
            state_d = (|digit_mask) ? DRIVE : IDLE;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt_d = '0;
            if (next_found) begin
              index_d = next_idx;
              tick_d  = 1'b1;
              state_d = GAP_STATE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [SEG_SCAN_PWM_W-1:0] pwm_cnt, pwm_d;

  // A fresh DRIVE is entered from another state or on a zero-gap digit handover.
  always_comb begin
    pwm_d = '0;
    if (state_d == DRIVE && state == DRIVE && cnt_d != '0) begin
      pwm_d = pwm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_d;
  end

  assign lit_d = (state_d == DRIVE) && digit_mask[index_d] && (pwm_d <= brightness);
`else
  assign lit_d = (state_d == DRIVE) && digit_mask[index_d];
`endif

  always_comb begin
    an_n_d = '1;
    if (lit_d) an_n_d[index_d] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      digit_index <= IDX_INIT;
      an_n        <= '1;
      digit_valid <= 1'b0;
      tick        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      digit_index <= index_d;
      an_n        <= an_n_d;
      digit_valid <= lit_d;
      tick        <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench: two scanners (4 digits with gap, 3 digits without)
// compared cycle by cycle against a slot-arithmetic reference model.
module tb_seg_scan_ctrl;

  localparam int NS[2] = '{4, 3};
  localparam int PS[2] = '{4, 3};
  localparam int BS[2] = '{2, 0};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] mask;

  logic [3:0] a_an_n;
  logic [1:0] a_idx;
  logic       a_valid, a_tick;
  logic [2:0] b_an_n;
  logic [1:0] b_idx;
  logic       b_valid, b_tick;

  int vectors     = 0;
  int miscompares = 0;
  int cur[2];

  always #5 clk = ~clk;

`ifdef SEG_SCAN_BRIGHTNESS_EN
  logic [3:0] brightness;
  logic [3:0] c_an_n;
  logic [1:0] c_idx;
  logic       c_valid, c_tick;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(16), .BLANK_CYCLES(2)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask), .brightness(brightness),
    .an_n(c_an_n), .digit_index(c_idx), .digit_valid(c_valid), .tick(c_tick)
  );
`endif

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .an_n(a_an_n), .digit_index(a_idx), .digit_valid(a_valid), .tick(a_tick)
  );

  seg_scan_ctrl #(.NUM_DIGITS(3), .PRESCALE(3), .BLANK_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .digit_mask(mask[2:0]),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .an_n(b_an_n), .digit_index(b_idx), .digit_valid(b_valid), .tick(b_tick)
  );

  // Nearest enabled digit walking downward modulo n; -1 when none is enabled.
  function automatic int sel_next(input int n, input int m, input int start, input bit incl);
    for (int k = (incl ? 0 : 1); k <= n; k++) begin
      int c;
      c = ((start - k) % n + n) % n;
      if (m[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] pack_exp(input bit lit, input int digit, input bit tk);
    logic [3:0] an;
    an = 4'hF;
    if (lit) an[digit] = 1'b0;
    return {an, 2'(digit), lit, tk};
  endfunction

  function automatic logic [7:0] observe(input int d);
    if (d == 0) return {a_an_n, a_idx, a_valid, a_tick};
    return {1'b1, b_an_n, b_idx, b_valid, b_tick};
  endfunction

  // Enable for 'cycles' cycles (mask switches to m2 from cycle chg_t), checking
  // every cycle of both scanners, then disable and check the idle state.
  task automatic run_scan(input logic [3:0] m, input int cycles, input int chg_t,
                          input logic [3:0] m2);
    int         digit[2];
    bit         running[2];
    logic [3:0] mt;
    int         md, pos;
    bit         lit, tk;
    logic [7:0] exp, got;
    for (int d = 0; d < 2; d++) begin
      md         = int'(m) & ((1 << NS[d]) - 1);
      running[d] = (md != 0);
      digit[d]   = running[d] ? sel_next(NS[d], md, cur[d], 1'b1) : cur[d];
    end
    for (int t = 0; t < cycles; t++) begin
      mt   = (chg_t >= 0 && t >= chg_t) ? m2 : m;
      mask = mt;
      en   = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        md  = int'(mt) & ((1 << NS[d]) - 1);
        pos = t % (BS[d] + PS[d]);
        tk  = running[d] && pos == 0 && t > 0;
        if (tk) digit[d] = sel_next(NS[d], md, digit[d], 1'b0);
        lit = running[d] && pos >= BS[d] && md[digit[d]];
        exp = pack_exp(lit, digit[d], tk);
        got = observe(d);
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL scan dut%0d t=%0d mask=%b: an/idx/valid/tick got %b expected %b",
                   d, t, mt, got, exp);
        end
      end
    end
    for (int d = 0; d < 2; d++) if (running[d]) cur[d] = digit[d];
    en = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      exp = pack_exp(1'b0, cur[d], 1'b0);
      got = observe(d);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL disable dut%0d: an/idx/valid/tick got %b expected %b", d, got, exp);
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cur = '{3, 2};
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    mask = 4'h0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (observe(d) !== pack_exp(1'b0, NS[d] - 1, 1'b0)) begin
        miscompares++;
        $display("FAIL reset dut%0d: got %b expected %b", d, observe(d),
                 pack_exp(1'b0, NS[d] - 1, 1'b0));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cur = '{3, 2};
    @(negedge clk);
    vectors++;
    if (observe(0) !== pack_exp(1'b0, 3, 1'b0)) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b expected %b", observe(0), pack_exp(1'b0, 3, 1'b0));
    end
  endtask

  task automatic test_full_scan();
    pulse_reset();
    run_scan(4'b1111, 30, -1, 4'b0000);
  endtask

  task automatic test_sparse_mask();
    run_scan(4'b0101, 24, -1, 4'b0000);
  endtask

  task automatic test_empty_mask();
    run_scan(4'b0000, 8, -1, 4'b0000);
    run_scan(4'b1000, 18, -1, 4'b0000);
  endtask

  task automatic test_disable_mid_drive();
    pulse_reset();
    run_scan(4'b1111, 16, -1, 4'b0000);
    run_scan(4'b1111, 6, -1, 4'b0000);
  endtask

  task automatic test_mask_clear_in_drive();
    pulse_reset();
    run_scan(4'b1111, 20, 4, 4'b0111);
  endtask

  task automatic test_async_reset();
    int         da;
    logic [3:0] exp_an;
    da   = sel_next(4, 15, cur[0], 1'b1);
    mask = 4'b1111;
    en   = 1'b1;
    repeat (4) @(negedge clk);
    exp_an     = 4'hF;
    exp_an[da] = 1'b0;
    vectors++;
    if (a_an_n !== exp_an) begin
      miscompares++;
      $display("FAIL pre_reset_drive: an_n got %b expected %b", a_an_n, exp_an);
    end
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (observe(d) !== pack_exp(1'b0, NS[d] - 1, 1'b0)) begin
        miscompares++;
        $display("FAIL async_reset dut%0d: got %b expected %b", d, observe(d),
                 pack_exp(1'b0, NS[d] - 1, 1'b0));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    cur = '{3, 2};
  endtask

  task automatic test_random();
    logic [3:0] m, m2;
    int         cycles, chg_t;
    for (int i = 0; i < 12; i++) begin
      m      = 4'($urandom_range(1, 15));
      cycles = $urandom_range(5, 40);
      chg_t  = -1;
      m2     = 4'h0;
      if (m[2:0] != 3'b000 && $urandom_range(0, 1) == 1) begin
        chg_t = $urandom_range(1, cycles - 1);
        do m2 = 4'($urandom_range(1, 15)); while (m2[2:0] == 3'b000);
      end
      run_scan(m, cycles, chg_t, m2);
    end
  endtask

`ifdef SEG_SCAN_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [3:0] levels[3];
    bit         exp_low;
    levels = '{4'd3, 4'd15, 4'($urandom_range(0, 15))};
    for (int l = 0; l < 3; l++) begin
      brightness = levels[l];
      pulse_reset();
      mask = 4'b1111;
      en   = 1'b1;
      for (int t = 0; t < 18; t++) begin
        @(negedge clk);
        exp_low = (t >= 2) && (t - 2 <= int'(levels[l]));
        vectors++;
        if ((c_an_n[3] === 1'b0) !== exp_low || c_valid !== exp_low) begin
          miscompares++;
          $display("FAIL brightness=%0d t=%0d: an_n=%b valid=%b expected lit=%b",
                   levels[l], t, c_an_n, c_valid, exp_low);
        end
      end
    end
    brightness = 4'd15;
    pulse_reset();
  endtask
`endif

  initial begin
`ifdef SEG_SCAN_BRIGHTNESS_EN
    brightness = 4'd15;
`endif
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_empty_mask();
    test_disable_mid_drive();
    test_mask_clear_in_drive();
    test_async_reset();
    test_random();
`ifdef SEG_SCAN_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
